// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial sequence family (transmitter and detectors).
package seq_fsm_pkg;

    // Transmitter state encoding.
    typedef enum logic [1:0] {
        TX_IDLE = 2'b00,
        TX_SEND = 2'b01,
        TX_GAP  = 2'b10,
        TX_DONE = 2'b11
    } tx_state_t;

    // Default pattern, also recognised by the detector blocks.
    localparam logic [4:0] PAT_11011 = 5'b11011;

endpackage : seq_fsm_pkg

// File: rtl/pattern_shifter.sv
// Parallel-load, shift-left register; msb is the bit currently on the line.
// Bits shifted in are FILL, so after a full pattern has been shifted out the
// register holds only FILL and msb naturally presents the idle level.
module pattern_shifter
    import seq_fsm_pkg::*;
#(
    parameter int             W       = 5,
    parameter logic [W-1:0]   PATTERN = PAT_11011,
    parameter logic           FILL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    input  logic clear,
    output logic msb
);

    logic [W-1:0] sreg;

    // Shift register: clear beats load, load beats shift.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= {W{FILL}};
        end else if (clear) begin
            sreg <= {W{FILL}};
        end else if (load) begin
            sreg <= PATTERN;
        end else if (shift) begin
            sreg <= {sreg[W-2:0], FILL};
        end
    end

    assign msb = sreg[W-1];

endmodule : pattern_shifter

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first repeat_n times with
// gap_n idle cycles between copies. All outputs come straight from registers.
module seq_pattern_tx
    import seq_fsm_pkg::*;
#(
    parameter int                 PAT_LEN  = 5,
    parameter logic [PAT_LEN-1:0] PATTERN  = PAT_11011,
    parameter int                 CNT_W    = 4,
    parameter int                 GAP_W    = 4,
    parameter logic               IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_n,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_LEN - 1);

    tx_state_t        state, state_d;
    logic [IDX_W-1:0] bit_idx, bit_idx_d;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic [GAP_W-1:0] gap_len, gap_len_d;
    logic             sh_load, sh_shift, sh_clear;

    // Line data comes from the shifter; its fill value is the idle level.
    pattern_shifter #(
        .W       (PAT_LEN),
        .PATTERN (PATTERN),
        .FILL    (IDLE_BIT)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .clear (sh_clear),
        .msb   (ser_out)
    );

    // Next-state, counter and shifter-control logic.
    // NOTE: every signal gets a default before the case; any path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        rep_cnt_d = rep_cnt;
        gap_cnt_d = gap_cnt;
        gap_len_d = gap_len;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_clear  = 1'b0;

        case (state)
            TX_IDLE: begin
                if (start) begin
                    if (repeat_n != '0) begin
                        rep_cnt_d = repeat_n;
                        gap_len_d = gap_n;
                        bit_idx_d = IDX_MSB;
                        sh_load   = 1'b1;
                        state_d   = TX_SEND;
                    end else begin
                        state_d   = TX_DONE;
                    end
                end
            end

            TX_SEND: begin
                if (abort) begin
                    state_d   = TX_IDLE;
                    sh_clear  = 1'b1;
                    bit_idx_d = '0;
                    rep_cnt_d = '0;
                    gap_cnt_d = '0;
                    gap_len_d = '0;
                end else if (bit_idx != '0) begin
                    bit_idx_d = bit_idx - 1'b1;
                    sh_shift  = 1'b1;
                end else if (rep_cnt == CNT_W'(1)) begin
                    // Last bit of the last copy.
                    rep_cnt_d = '0;
                    sh_shift  = 1'b1;
                    state_d   = TX_DONE;
                end else begin
                    rep_cnt_d = rep_cnt - 1'b1;
                    if (gap_len == '0) begin
                        bit_idx_d = IDX_MSB;
                        sh_load   = 1'b1;
                    end else begin
                        gap_cnt_d = gap_len;
                        sh_shift  = 1'b1;
                        state_d   = TX_GAP;
                    end
                end
            end

            TX_GAP: begin
                if (abort) begin
                    state_d   = TX_IDLE;
                    sh_clear  = 1'b1;
                    bit_idx_d = '0;
                    rep_cnt_d = '0;
                    gap_cnt_d = '0;
                    gap_len_d = '0;
                end else if (gap_cnt == GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    bit_idx_d = IDX_MSB;
                    sh_load   = 1'b1;
                    state_d   = TX_SEND;
                end else begin
                    gap_cnt_d = gap_cnt - 1'b1;
                end
            end

            TX_DONE: begin
                state_d = TX_IDLE;
            end

            default: begin
                state_d  = TX_IDLE;
                sh_clear = 1'b1;
            end
        endcase
    end

    // State, counters and registered status outputs derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= TX_IDLE;
            bit_idx     <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
            gap_len     <= '0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            bit_idx     <= bit_idx_d;
            rep_cnt     <= rep_cnt_d;
            gap_cnt     <= gap_cnt_d;
            gap_len     <= gap_len_d;
            ser_valid   <= (state_d == TX_SEND);
            frame_start <= (state_d == TX_SEND) && (bit_idx_d == IDX_MSB);
            busy        <= (state_d != TX_IDLE);
            done        <= (state_d == TX_DONE);
        end
    end

endmodule : seq_pattern_tx

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx. Expected per-cycle outputs are built
// from the transmission rules as a queue of {ser_out, ser_valid, frame_start,
// busy, done} words.
module tb_seq_pattern_tx;

    localparam int                 PAT_LEN = 5;
    localparam logic [PAT_LEN-1:0] PAT     = 5'b11011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] repeat_n = '0;
    logic [3:0] gap_n = '0;
    logic       ser_out, ser_valid, frame_start, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_q[$];

    seq_pattern_tx #(
        .PAT_LEN  (PAT_LEN),
        .PATTERN  (PAT),
        .CNT_W    (4),
        .GAP_W    (4),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .repeat_n    (repeat_n),
        .gap_n       (gap_n),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {ser_out, ser_valid, frame_start, busy, done};
    endfunction

    // Expected cycles 1.. after start: R copies, G idle cycles between them,
    // one done cycle, then one idle cycle.
    task automatic build_exp(input int r, input int g);
        exp_q.delete();
        if (r > 0) begin
            for (int c = 0; c < r; c++) begin
                for (int b = PAT_LEN - 1; b >= 0; b--)
                    exp_q.push_back({PAT[b], 1'b1, (b == PAT_LEN - 1), 1'b1, 1'b0});
                if (c < r - 1)
                    for (int k = 0; k < g; k++) exp_q.push_back(5'b00010);
            end
        end
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);
    endtask

    // Issue start in the current (IDLE) cycle; returns one cycle later.
    task automatic kick(input int r, input int g);
        start    = 1'b1;
        repeat_n = 4'(r);
        gap_n    = 4'(g);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL reset_async: got %b want 00000", obs());
        end
        @(posedge clk); #1;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL reset_held: got %b want 00000", obs());
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL reset_idle: got %b want 00000", obs());
        end
    endtask

    task automatic test_single();
        build_exp(1, 0);
        kick(1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL single cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] win = '0;
        int since = 0;
        int det = 0;
        build_exp(2, 0);
        kick(2, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL b2b cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            // Non-overlapping 11011 detector fed from the live stream.
            if (ser_valid === 1'b1) begin
                win = {win[3:0], ser_out};
                since++;
                if (since >= 5 && win == 5'b11011) begin
                    det++;
                    since = 0;
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (det !== 2) begin
            n_bad++; $display("FAIL b2b_detections: got %0d want 2", det);
        end
    endtask

    task automatic test_gapped();
        build_exp(3, 2);
        kick(3, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL gapped cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero();
        build_exp(0, 5);
        kick(0, 5);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL zero cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        build_exp(2, 1);
        kick(2, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL abort_pre cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            if (i == 2) abort = 1'b1;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_bad++; $display("FAIL abort_post cyc %0d: got %b want 00000", i + 4, obs());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignored_start();
        int g = $urandom_range(0, 3);
        build_exp(2, g);
        kick(2, g);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL ign_start cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            // start in SEND and in DONE, abort in DONE: all must be ignored.
            start = (i == 1) || (i == exp_q.size() - 2);
            abort = (i == exp_q.size() - 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        build_exp(3, 4);
        kick(3, 4);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL arst_pre cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            if (i < 6) begin
                @(posedge clk); #1;
            end
        end
        // Now mid-GAP, between edges.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL arst_immediate: got %b want 00000", obs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL arst_released: got %b want 00000", obs());
        end
        build_exp(1, 0);
        kick(1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs() !== exp_q[i]) begin
                n_bad++; $display("FAIL arst_after cyc %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            int r = $urandom_range(0, 15);
            int g = $urandom_range(0, 15);
            build_exp(r, g);
            kick(r, g);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs() !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL random f%0d r=%0d g=%0d cyc %0d: got %b want %b",
                             f, r, g, i + 1, obs(), exp_q[i]);
                end
                // Noise on inputs after capture; keep start low in the idle cycle.
                start    = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                repeat_n = 4'($urandom_range(0, 15));
                gap_n    = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_zero();
        test_abort();
        test_ignored_start();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_pattern_tx

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the generator counterpart to the team's serial sequence detectors.
- On a start request it serialises a fixed bit pattern MSB-first (default 11011), repeated N times, with a programmable idle gap between repeats.
- Used as stimulus source and loopback partner for the Moore/Mealy detector blocks.
- Moore-style: all outputs are registered and depend only on state and counters.

Parameters:
- PAT_LEN, 5, pattern length in bits (2..16).
- PATTERN, 5'b11011, pattern transmitted MSB (bit PAT_LEN-1) first.
- CNT_W, 4, width of the repeat-count input.
- GAP_W, 4, width of the gap-length input.
- IDLE_BIT, 1'b0, value driven on ser_out whenever ser_valid=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  transmission request, sampled only in IDLE.
- abort  input  1  synchronous cancel, honoured in SEND/GAP.
- repeat_n  input  CNT_W  number of pattern copies, captured at start.
- gap_n  input  GAP_W  idle cycles between copies, captured at start.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a pattern bit this cycle.
- frame_start  output  1  high during the first bit of each copy.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after normal completion.

Behaviour:
- Reset (async, any state): state=IDLE; ser_out=IDLE_BIT; ser_valid, frame_start, busy, done = 0; counters cleared.
- States and encoding: IDLE, SEND, GAP, DONE, encoded 2'b00, 2'b01, 2'b10, 2'b11.
- IDLE:
  - start=1 and repeat_n!=0: capture repeat_n and gap_n, load the shifter with PATTERN, go to SEND.
  - start=1 and repeat_n==0: go to DONE (no bits sent).
  - Otherwise stay in IDLE.
- SEND:
  - One pattern bit per cycle, bit index PAT_LEN-1 down to 0.
  - ser_valid=1; frame_start=1 on index PAT_LEN-1 only.
  - After index 0, if this was the last copy, go to DONE.
  - After index 0, with copies remaining and captured gap==0, reload PATTERN and stay in SEND (back-to-back bits).
  - After index 0, with copies remaining and captured gap>0, go to GAP.
- GAP:
  - Lasts exactly gap cycles; ser_valid=0, ser_out=IDLE_BIT.
  - Then reload PATTERN and go to SEND.
- DONE:
  - Lasts exactly one cycle; done=1, busy=1, ser_valid=0.
  - Then go to IDLE.
- Latency:
  - Start sampled high at edge k: first bit is visible in cycle k+1.
  - For R>0 copies and gap G: total bit-plus-gap cycles = R*PAT_LEN + (R-1)*G.
  - done is high the cycle immediately after the last bit.
- start outside IDLE (including DONE) is ignored. Changes to repeat_n or gap_n after capture have no effect.
- abort in SEND or GAP: the next cycle is IDLE with all outputs at reset values and no done pulse. abort in IDLE or DONE is ignored. abort has priority over normal progression.
- start and abort both high in IDLE: start wins (abort is ignored in IDLE).
- Counters:
  - Repeat counter is CNT_W bits and decrements per completed copy, so the maximum is 2^CNT_W-1 copies.
  - Gap counter is GAP_W bits.
  - Bit index counter is clog2(PAT_LEN) bits.
  - No counter wraps in legal operation.
- Illegal state encodings (none exist with a 2-bit encoding; the default branch still applies): return to IDLE.

Decomposition:
- Shared package seq_fsm_pkg holds:
  - the state encoding localparams (TX_IDLE, TX_SEND, TX_GAP, TX_DONE);
  - the default pattern constant PAT_11011 = 5'b11011, also used by the detector blocks.
- One sub-module is natural: pattern_shifter. It is a PAT_LEN-bit parallel-load, shift-left register with load, shift and msb outputs.
- The top-level FSM owns the counters and output registers.

Test Plan:
- Single copy: repeat_n=1, gap_n=0, start at cycle 0 -> ser_out=1,1,0,1,1 in cycles 1-5 with ser_valid=1; frame_start=1 in cycle 1 only; done=1 in cycle 6; busy=1 in cycles 1-6; IDLE in cycle 7.
- Back-to-back: repeat_n=2, gap_n=0 -> cycles 1-10 carry 1101111011 with continuous ser_valid; frame_start in cycles 1 and 6; done in cycle 11. Loop the stream into the team's 11011 non-overlapping Moore detector -> exactly 2 detections.
- Gapped: repeat_n=3, gap_n=2 -> copies in cycles 1-5, 8-12 and 15-19; ser_valid=0 and ser_out=0 in cycles 6-7 and 13-14; done in cycle 20.
- Zero repeats: repeat_n=0, start at cycle 0 -> done=1 and busy=1 in cycle 1 only; ser_valid never asserted.
- Abort and ignored start: repeat_n=2 with abort=1 during the 3rd bit (cycle 3) -> cycle 4 is IDLE, all outputs 0, no done. A start pulse at cycle 2 in a separate run is ignored and the stream is unchanged.
- Async reset mid-GAP: rst asserted between edges -> outputs go to 0 immediately without waiting for a clock edge. After release, a new start produces the full sequence from bit 1 with no done pulse left over from before.
